// File: rtl/park_pkg.sv
// Shared definitions for the parking gate controller: FSM state encoding,
// default gate timeout and car-count width.
package park_pkg;

  localparam int unsigned GateTimeoutDefault = 16;
  localparam int unsigned CarCntW            = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle      = 2'd0;
  localparam state_t StEntryOpen = 2'd1;
  localparam state_t StExitOpen  = 2'd2;

  function automatic logic state_is_open(input state_t s);
    return (s == StEntryOpen) || (s == StExitOpen);
  endfunction

endpackage

// File: rtl/park_gate_timer.sv
// Open-gate timeout counter: 8-bit up-counter with synchronous clear/enable;
// expired_o flags the last allowed open cycle.
module park_gate_timer
  import park_pkg::*;
#(
  parameter int unsigned Limit = GateTimeoutDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LastCnt = 8'(Limit - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the FSM leaves the open state after exactly Limit cycles.
  assign expired_o = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: sticky entry/exit requests, round-robin arbitration,
// one gate open at a time. Define PARK_GATE_TIMEOUT_EN to auto-close idle gates.
module parking_gate_ctrl
  import park_pkg::*;
#(
  parameter int unsigned GATE_TIMEOUT = GateTimeoutDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_req,
  input  logic exit_req,
  input  logic car_passed,
  input  logic is_full,
  input  logic is_empty,
  output logic count_up,
  output logic count_down,
  output logic gate_in_open,
  output logic gate_out_open,
  output logic denied,
  output logic busy
);

  if (GATE_TIMEOUT < 2 || GATE_TIMEOUT > 255) begin : g_bad_timeout
    $error("GATE_TIMEOUT out of range 2..255");
  end

  state_t state_q, state_d;
  logic   entry_pend_q, entry_pend_d;
  logic   exit_pend_q, exit_pend_d;
  logic   rr_entry_q, rr_entry_d;
  logic   count_up_q, count_up_d;
  logic   count_down_q, count_down_d;
  logic   denied_q, denied_d;
  logic   entry_clr, exit_clr;
  logic   pick_entry, pick_exit;
  logic   timeout;

`ifdef PARK_GATE_TIMEOUT_EN
  park_gate_timer #(
    .Limit(GATE_TIMEOUT)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (!state_is_open(state_q)),
    .enable_i (state_is_open(state_q)),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_entry_d   = rr_entry_q;
    count_up_d   = 1'b0;
    count_down_d = 1'b0;
    denied_d     = 1'b0;
    entry_clr    = 1'b0;
    exit_clr     = 1'b0;
    pick_entry   = 1'b0;
    pick_exit    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // rr_entry_q set means entry wins a tie.
        pick_entry = entry_pend_q && (!exit_pend_q || rr_entry_q);
        pick_exit  = exit_pend_q && !pick_entry;
        if (pick_entry) begin
          entry_clr = 1'b1;
          if (is_full) begin
            denied_d = 1'b1;
          end else begin
            state_d    = StEntryOpen;
            rr_entry_d = 1'b0;
          end
        end else if (pick_exit) begin
          exit_clr = 1'b1;
          if (is_empty) begin
            denied_d = 1'b1;
          end else begin
            state_d    = StExitOpen;
            rr_entry_d = 1'b1;
          end
        end
      end
      StEntryOpen: begin
        if (car_passed) begin
          state_d    = StIdle;
          count_up_d = 1'b1;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StExitOpen: begin
        if (car_passed) begin
          state_d      = StIdle;
          count_down_d = 1'b1;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request seen on the clearing cycle is a new one and stays pending.
    entry_pend_d = (entry_pend_q && !entry_clr) || entry_req;
    exit_pend_d  = (exit_pend_q && !exit_clr) || exit_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      rr_entry_q   <= 1'b1;
      count_up_q   <= 1'b0;
      count_down_q <= 1'b0;
      denied_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      rr_entry_q   <= rr_entry_d;
      count_up_q   <= count_up_d;
      count_down_q <= count_down_d;
      denied_q     <= denied_d;
    end
  end

  assign count_up      = count_up_q;
  assign count_down    = count_down_q;
  assign denied        = denied_q;
  assign gate_in_open  = (state_q == StEntryOpen);
  assign gate_out_open = (state_q == StExitOpen);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl; outputs packed as
// {busy, denied, gate_out_open, gate_in_open, count_down, count_up}.
module tb_parking_gate_ctrl;

  logic clk = 1'b0;
  logic reset, entry_req, exit_req, car_passed, is_full, is_empty;
  logic count_up, count_down, gate_in_open, gate_out_open, denied, busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [5:0] OutIdle    = 6'b000000;
  localparam logic [5:0] OutInOpen  = 6'b100100;
  localparam logic [5:0] OutOutOpen = 6'b101000;
  localparam logic [5:0] OutUp      = 6'b000001;
  localparam logic [5:0] OutDown    = 6'b000010;
  localparam logic [5:0] OutDenied  = 6'b010000;

  parking_gate_ctrl #(
    .GATE_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .car_passed   (car_passed),
    .is_full      (is_full),
    .is_empty     (is_empty),
    .count_up     (count_up),
    .count_down   (count_down),
    .gate_in_open (gate_in_open),
    .gate_out_open(gate_out_open),
    .denied       (denied),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {busy, denied, gate_out_open, gate_in_open, count_down, count_up};
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    car_passed = 1'b0;
    is_full    = 1'b0;
    is_empty   = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("reset_outs", outs(), OutIdle);

    // Entry, car passes after 5 open cycles.
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    check_eq("entry_latched", outs(), OutIdle);
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("entry_open_%0d", i), outs(), OutInOpen);
      if (i == 4) car_passed = 1'b1;
      step();
    end
    car_passed = 1'b0;
    check_eq("entry_count_up", outs(), OutUp);
    step();
    check_eq("entry_up_single", outs(), OutIdle);

    // Entry while full is denied.
    is_full   = 1'b1;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    step();
    check_eq("full_denied", outs(), OutDenied);
    step();
    check_eq("full_denied_once", outs(), OutIdle);
    step();
    check_eq("full_pend_cleared", outs(), OutIdle);
    is_full = 1'b0;

    // Simultaneous requests after reset: entry first, then exit.
    do_reset();
    entry_req = 1'b1;
    exit_req  = 1'b1;
    step();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    step();
    check_eq("both_entry_first", outs(), OutInOpen);
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    check_eq("both_count_up", outs(), OutUp);
    step();
    check_eq("both_exit_second", outs(), OutOutOpen);
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    check_eq("both_count_down", outs(), OutDown);
    step();
    check_eq("both_done", outs(), OutIdle);

    // Exit while empty is denied.
    is_empty = 1'b1;
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
    check_eq("empty_denied", outs(), OutDenied);
    step();
    check_eq("empty_denied_once", outs(), OutIdle);
    is_empty = 1'b0;

    // Reset while exit gate is open discards a pending entry.
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
    check_eq("rst_exit_open", outs(), OutOutOpen);
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    check_eq("rst_entry_held", outs(), OutOutOpen);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_outs_zero", outs(), OutIdle);
    step();
    step();
    check_eq("rst_entry_dropped", outs(), OutIdle);

    // car_passed in idle does nothing.
    car_passed = 1'b1;
    step();
    step();
    car_passed = 1'b0;
    check_eq("idle_car_passed", outs(), OutIdle);

    // Exit granted with no car_passed.
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
`ifdef PARK_GATE_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("timeout_open_%0d", i), outs(), OutOutOpen);
      step();
    end
    check_eq("timeout_closed", outs(), OutIdle);
`else
    for (int i = 0; i < 20; i++) step();
    check_eq("no_timeout_still_open", outs(), OutOutOpen);
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    check_eq("no_timeout_count_down", outs(), OutDown);
`endif
    step();
    check_eq("final_idle", outs(), OutIdle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 The parameter list SHALL be: GATE_TIMEOUT, default 16, the number of open-gate cycles before the gate auto-closes (legal range 2..255).
REQ-002 Port: clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 Port: entry_req  input  1  entry button/sensor pulse; level-high for one or more cycles.
REQ-005 Port: exit_req  input  1  exit button/sensor pulse; level-high for one or more cycles.
REQ-006 Port: car_passed  input  1  beam sensor; high when the car clears the currently open gate.
REQ-007 Port: is_full  input  1  occupancy-full flag from the car counter.
REQ-008 Port: is_empty  input  1  occupancy-empty flag from the car counter.
REQ-009 Port: count_up  output  1  one-cycle increment strobe to the car counter.
REQ-010 Port: count_down  output  1  one-cycle decrement strobe to the car counter.
REQ-011 Port: gate_in_open  output  1  entry gate motor open command.
REQ-012 Port: gate_out_open  output  1  exit gate motor open command.
REQ-013 Port: denied  output  1  one-cycle strobe: a request was rejected (entry while full, or exit while empty).
REQ-014 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL latch entry_req and exit_req into sticky pending flags (entry_pend, exit_pend), set on any cycle the input is high and cleared only when that request is granted or denied.
REQ-016 The FSM SHALL have exactly three states: IDLE, ENTRY_OPEN and EXIT_OPEN.
REQ-017 In IDLE with only entry_pend set, the block SHALL go to ENTRY_OPEN next cycle if is_full=0; if is_full=1 it SHALL instead pulse denied and clear entry_pend while staying in IDLE.
REQ-018 In IDLE with only exit_pend set, the block SHALL go to EXIT_OPEN next cycle if is_empty=0; if is_empty=1 it SHALL instead pulse denied and clear exit_pend while staying in IDLE.
REQ-019 With both flags pending in IDLE, the block SHALL grant round-robin: serve the direction not served last; after reset, entry has priority.
REQ-020 A grant SHALL clear the granted pending flag; a request arriving while busy SHALL be held pending, not lost.
REQ-021 gate_in_open SHALL equal (state==ENTRY_OPEN) and gate_out_open SHALL equal (state==EXIT_OPEN), registered; both SHALL never be high together.
REQ-022 In ENTRY_OPEN, car_passed=1 SHALL return the FSM to IDLE next cycle and pulse count_up for exactly that one cycle.
REQ-023 In EXIT_OPEN, car_passed=1 SHALL return the FSM to IDLE next cycle and pulse count_down for exactly that one cycle.
REQ-024 count_up and count_down SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-025 car_passed while in IDLE SHALL be ignored.

Reset
REQ-026 On reset=1, the block SHALL set: state=IDLE, both pending flags=0, round-robin pointer to favour entry, timer=0, and all outputs=0 on the following cycle.
REQ-027 A reset while a gate is open SHALL close the gate with no count strobe and discard pending requests.

Configuration
REQ-028 With PARK_GATE_TIMEOUT_EN defined, an open gate with no car_passed for GATE_TIMEOUT consecutive open cycles SHALL return the FSM to IDLE with no count strobe.
REQ-029 Without PARK_GATE_TIMEOUT_EN, the gate SHALL stay open until car_passed, the timer logic SHALL be absent, and GATE_TIMEOUT SHALL be unused.

Structure
REQ-030 A shared package park_pkg SHALL hold the FSM state enum, the GATE_TIMEOUT default, and the car-count width (2).
REQ-031 The timeout counter SHALL be one sub-module, park_gate_timer: 8-bit, with clear, enable and expired ports, instantiated only under PARK_GATE_TIMEOUT_EN.

Verification
REQ-032 Entry with is_full=0, then car_passed 5 cycles after the grant -> gate_in_open high for 5 cycles, one count_up pulse, then IDLE.
REQ-033 Entry with is_full=1 -> one denied pulse, gate_in_open stays 0, count_up stays 0.
REQ-034 entry_req and exit_req in the same cycle, is_full=0, is_empty=0 -> entry served first, exit served after entry's car_passed, count_up then count_down.
REQ-035 With PARK_GATE_TIMEOUT_EN and GATE_TIMEOUT=16, exit granted with no car_passed -> gate_out_open high for exactly 16 cycles, no count_down.
REQ-036 reset asserted while in EXIT_OPEN -> next cycle all outputs are 0, the FSM is in IDLE, and a pending entry is discarded.
REQ-037 exit_req with is_empty=1 -> one denied pulse, gate_out_open stays 0.
